// File: rtl/spi_master_fifo_if.sv
// spi_master_fifo_if: CPU register-bus side of the SPI master.
// Word-addressed strobe bus with registered read data and level irq.
interface spi_master_fifo_if;
   logic [2:0]  addr;
   logic        wr;
   logic        rd;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        irq;

   modport master (
      output addr, wr, rd, wdata,
      input  rdata, irq
   );

   modport slave (
      input  addr, wr, rd, wdata,
      output rdata, irq
   );
endinterface

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: SPI master with TX/RX FIFOs, run-time CPOL/CPHA,
// LSB-first and clock divider, driven from the CPU register bus.
module spi_master_fifo #(
   parameter int DATA_W     = 8,
   parameter int NUM_SS     = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   spi_master_fifo_if.slave  bus,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic [NUM_SS-1:0] SS_n
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(2 * DATA_W);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST = BW'(2 * DATA_W - 1);

   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

   state_t            state;
   logic [6:0]        ctrl;
   logic [DIV_W-1:0]  clkdiv, sh_div, div_cnt;
   logic [NUM_SS-1:0] ssel;
   logic              toe, roe, sh_cpha, sh_lsb;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg, rxsh;

   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [PW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0]     tx_cnt, rx_cnt;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tmt, tick, samp, clr, ld_mosi;
   logic tx_push_req, tx_push, tx_pop;
   logic rx_push_req, rx_push, rx_pop;
   logic [DATA_W-1:0] tx_head, ld_sh;
   logic [6:0]        status;
   logic [15:0]       rd_mux;
   logic              unused_ok;

   function automatic logic [DATA_W-1:0] shift(
      input logic [DATA_W-1:0] d,
      input logic              lsb
   );
      return lsb ? d >> 1 : d << 1;
   endfunction

   assign unused_ok   = &{1'b0, bus.wdata};
   assign tx_empty    = tx_cnt == '0;
   assign tx_full     = tx_cnt == FULL;
   assign rx_empty    = rx_cnt == '0;
   assign rx_full     = rx_cnt == FULL;
   assign tick        = div_cnt == '0;
   assign tmt         = tx_empty && state == IDLE;
   assign clr         = bus.wr && bus.addr == 3'd2;

   // FSM pops in IDLE, or at TRAIL end for a back-to-back word
   assign tx_pop      = !tx_empty &&
                        (state == IDLE || (state == TRAIL && tick));
   assign tx_push_req = bus.wr && bus.addr == 3'd1;
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign rx_push_req = state == TRAIL && tick;
   assign rx_pop      = bus.rd && bus.addr == 3'd0 && !rx_empty;
   assign rx_push     = rx_push_req && (!rx_full || rx_pop);

   assign samp        = bit_cnt[0] == sh_cpha;
   assign tx_head     = tx_mem[tx_rp];
   assign ld_mosi     = ctrl[2] ? tx_head[0] : tx_head[DATA_W-1];
   assign ld_sh       = ctrl[1] ? tx_head : shift(tx_head, ctrl[2]);

   assign status = {state != IDLE, roe, toe, rx_full,
                    !rx_empty, tx_full, tmt};

   always_comb begin
      rd_mux = '0;
      case (bus.addr)
         3'd0: rd_mux = rx_empty ? '0 : 16'(rx_mem[rx_rp]);
         3'd2: rd_mux = 16'(status);
         3'd3: rd_mux = 16'(ctrl);
         3'd4: rd_mux = 16'(clkdiv);
         3'd5: rd_mux = 16'(ssel);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= bus.wdata[DATA_W-1:0];
      if (rx_push) rx_mem[rx_wp] <= rxsh;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + PW'(1);
         if (tx_pop)  tx_rp <= tx_rp + PW'(1);
         if (rx_push) rx_wp <= rx_wp + PW'(1);
         if (rx_pop)  rx_rp <= rx_rp + PW'(1);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl      <= '0;
         clkdiv    <= DIV_W'(9);
         ssel      <= NUM_SS'(1);
         toe       <= 1'b0;
         roe       <= 1'b0;
         bus.rdata <= '0;
         bus.irq   <= 1'b0;
      end else begin
         if (bus.wr) begin
            case (bus.addr)
               3'd3: ctrl   <= bus.wdata[6:0];
               3'd4: clkdiv <= bus.wdata[DIV_W-1:0];
               3'd5: ssel   <= bus.wdata[NUM_SS-1:0];
               default: ;
            endcase
         end
         toe <= (toe && !clr) || (tx_push_req && !tx_push);
         roe <= (roe && !clr) || (rx_push_req && !rx_push);
         if (bus.rd) bus.rdata <= rd_mux;
         bus.irq <= (!rx_empty && ctrl[4]) || (tmt && ctrl[5]) ||
                    ((toe || roe) && ctrl[6]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         rxsh    <= '0;
         sh_div  <= '0;
         sh_cpha <= 1'b0;
         sh_lsb  <= 1'b0;
         SCLK    <= 1'b0;
         MOSI    <= 1'b0;
         SS_n    <= '1;
      end else begin
         // word load: mode and divider are frozen here for the whole word
         if (tx_pop) begin
            shreg   <= ld_sh;
            sh_div  <= clkdiv;
            sh_cpha <= ctrl[1];
            sh_lsb  <= ctrl[2];
            SCLK    <= ctrl[0];
            div_cnt <= clkdiv;
            bit_cnt <= '0;
            if (!ctrl[1]) MOSI <= ld_mosi;
         end
         unique case (state)
            IDLE: begin
               if (tx_pop) begin
                  state <= LEAD;
                  SS_n  <= ~ssel;
               end else begin
                  SCLK    <= ctrl[0];
                  div_cnt <= '0;
                  SS_n    <= ctrl[3] ? ~ssel : '1;
               end
            end
            LEAD: begin
               if (tick) begin
                  state   <= XFER;
                  div_cnt <= sh_div;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            XFER: begin
               if (tick) begin
                  div_cnt <= sh_div;
                  SCLK    <= ~SCLK;
                  if (samp) begin
                     rxsh <= sh_lsb ? {MISO, rxsh[DATA_W-1:1]}
                                    : {rxsh[DATA_W-2:0], MISO};
                  end else begin
                     MOSI  <= sh_lsb ? shreg[0] : shreg[DATA_W-1];
                     shreg <= shift(shreg, sh_lsb);
                  end
                  if (bit_cnt == LAST) state <= TRAIL;
                  else bit_cnt <= bit_cnt + BW'(1);
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            TRAIL: begin
               if (!tick) begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end else if (tx_pop) begin
                  state <= XFER;
               end else begin
                  state <= IDLE;
                  SS_n  <= ctrl[3] ? ~ssel : '1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: directed bench for spi_master_fifo,
// MISO looped back to MOSI, expected values hand-computed.
module tb_spi_master_fifo;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       SCLK, MOSI, MISO;
   logic [0:0] SS_n;
   int         checks = 0;
   int         failures = 0;

   spi_master_fifo_if bus();

   spi_master_fifo #(
      .DATA_W(8), .NUM_SS(1), .FIFO_DEPTH(4), .DIV_W(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
   );

   assign MISO = MOSI;
   always #5 clk = ~clk;

   task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
      bus.wr = 1'b1;
      bus.addr = a;
      bus.wdata = d;
      @(negedge clk);
      bus.wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
      bus.rd = 1'b1;
      bus.addr = a;
      @(negedge clk);
      bus.rd = 1'b0;
      d = bus.rdata;
   endtask

   // follows SCLK until SS_n returns high; records sampled MOSI bits
   task automatic capture(
      input logic cpol, input logic cpha, input int limit,
      output int nlead, output logic [63:0] seq,
      output int wmin, output int wmax, output logic to
   );
      logic prev, seen;
      int cyc, last, w;
      prev = SCLK; seen = 1'b0; cyc = 0; last = -1;
      nlead = 0; seq = '0; wmin = 1 << 30; wmax = 0; to = 1'b1;
      while (cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (SS_n[0] == 1'b0) seen = 1'b1;
         if (SCLK !== prev) begin
            if (last >= 0) begin
               w = cyc - last;
               if (w < wmin) wmin = w;
               if (w > wmax) wmax = w;
            end
            last = cyc;
            if (prev == cpol) nlead++;
            if ((prev == cpol) != cpha) seq = {seq[62:0], MOSI};
            prev = SCLK;
         end
         if (seen && SS_n[0] === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      logic [2:0] a [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
      logic [15:0] e [6] = '{16'h1, 16'h0, 16'h9, 16'h1, 16'h0, 16'h0};
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({SS_n, SCLK, MOSI, bus.irq} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_pins got=%b want=1000",
                  {SS_n, SCLK, MOSI, bus.irq});
      end
      checks++;
      if (bus.rdata !== 16'h0) begin
         failures++;
         $display("FAIL reset_rdata got=%h want=0000", bus.rdata);
      end
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         rd_reg(a[i], d);
         checks++;
         if (d !== e[i]) begin
            failures++;
            $display("FAIL reset_reg%0d got=%h want=%h", a[i], d, e[i]);
         end
      end
   endtask

   task automatic test_mode0();
      int nl, wmn, wmx;
      logic [63:0] sq;
      logic to;
      logic [15:0] d;
      wr_reg(3'd1, 16'h00A5);
      capture(1'b0, 1'b0, 2000, nl, sq, wmn, wmx, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL m0_timeout got=timeout want=done");
      end
      checks++;
      if (nl != 8) begin
         failures++;
         $display("FAIL m0_pulses got=%0d want=8", nl);
      end
      checks++;
      if (wmn != 10 || wmx != 10) begin
         failures++;
         $display("FAIL m0_halfper got=%0d..%0d want=10", wmn, wmx);
      end
      checks++;
      if (sq[7:0] !== 8'hA5) begin
         failures++;
         $display("FAIL m0_mosi got=%h want=a5", sq[7:0]);
      end
      rd_reg(3'd0, d);
      checks++;
      if (d !== 16'h00A5) begin
         failures++;
         $display("FAIL m0_rx got=%h want=00a5", d);
      end
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h0001) begin
         failures++;
         $display("FAIL m0_status got=%h want=0001", d);
      end
   endtask

   task automatic test_modes();
      logic [15:0] c [4] = '{16'h2, 16'h1, 16'h3, 16'h4};
      logic [15:0] tx [4] = '{16'h3C, 16'h3C, 16'h3C, 16'h01};
      logic [7:0] bits [4] = '{8'h3C, 8'h3C, 8'h3C, 8'h80};
      int nl, wmn, wmx;
      logic [63:0] sq;
      logic to;
      logic [15:0] d;
      logic [15:0] cv;
      for (int i = 0; i < 4; i++) begin
         cv = c[i];
         wr_reg(3'd3, cv);
         @(negedge clk);
         checks++;
         if (SCLK !== cv[0]) begin
            failures++;
            $display("FAIL md%0d_idle got=%b want=%b", i, SCLK, cv[0]);
         end
         wr_reg(3'd1, tx[i]);
         capture(cv[0], cv[1], 2000, nl, sq, wmn, wmx, to);
         checks++;
         if (to || nl != 8 || wmn != 10 || wmx != 10) begin
            failures++;
            $display("FAIL md%0d_clk got=to%b n%0d w%0d..%0d want=8/10",
                     i, to, nl, wmn, wmx);
         end
         checks++;
         if (sq[7:0] !== bits[i]) begin
            failures++;
            $display("FAIL md%0d_mosi got=%h want=%h", i, sq[7:0], bits[i]);
         end
         checks++;
         if (SCLK !== cv[0]) begin
            failures++;
            $display("FAIL md%0d_end got=%b want=%b", i, SCLK, cv[0]);
         end
         rd_reg(3'd0, d);
         checks++;
         if (d !== tx[i]) begin
            failures++;
            $display("FAIL md%0d_rx got=%h want=%h", i, d, tx[i]);
         end
      end
      wr_reg(3'd3, 16'h0);
   endtask

   task automatic test_back_to_back();
      int nl, wmn, wmx;
      logic [63:0] sq;
      logic to;
      logic [15:0] d;
      for (int i = 0; i < 5; i++) wr_reg(3'd1, 16'h11 + 16'(i));
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h0042) begin
         failures++;
         $display("FAIL b2b_full got=%h want=0042", d);
      end
      wr_reg(3'd1, 16'h16);
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h0052) begin
         failures++;
         $display("FAIL b2b_toe got=%h want=0052", d);
      end
      capture(1'b0, 1'b0, 4000, nl, sq, wmn, wmx, to);
      checks++;
      if (to || nl != 40) begin
         failures++;
         $display("FAIL b2b_ss got=to%b n%0d want=40", to, nl);
      end
      checks++;
      if (sq[39:0] !== 40'h1112131415) begin
         failures++;
         $display("FAIL b2b_mosi got=%h want=1112131415", sq[39:0]);
      end
   endtask

   task automatic test_rx_overrun();
      logic [15:0] d;
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h003D) begin
         failures++;
         $display("FAIL ovr_status got=%h want=003d", d);
      end
      for (int i = 0; i < 4; i++) begin
         rd_reg(3'd0, d);
         checks++;
         if (d !== 16'h11 + 16'(i)) begin
            failures++;
            $display("FAIL ovr_rx%0d got=%h want=%h", i, d, 16'h11 + 16'(i));
         end
      end
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h0031) begin
         failures++;
         $display("FAIL ovr_drained got=%h want=0031", d);
      end
      wr_reg(3'd2, 16'hFFFF);
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h0001) begin
         failures++;
         $display("FAIL ovr_clear got=%h want=0001", d);
      end
   endtask

   task automatic test_irq_fast();
      logic [15:0] d;
      logic tmt_h [41];
      int rise, ntog, first_t, last_t, nhigh;
      logic prev;
      wr_reg(3'd4, 16'h0);
      wr_reg(3'd3, 16'h20);
      @(negedge clk);
      checks++;
      if (bus.irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_idle got=%b want=1", bus.irq);
      end
      wr_reg(3'd1, 16'h5A);
      bus.rd = 1'b1;
      bus.addr = 3'd2;
      rise = -1; ntog = 0; first_t = -1; last_t = -1; nhigh = 0;
      prev = SCLK;
      tmt_h[0] = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         tmt_h[n] = bus.rdata[0];
         if (rise < 0 && bus.irq === 1'b1) rise = n;
         if (SCLK !== prev) begin
            ntog++;
            if (first_t < 0) first_t = n;
            last_t = n;
            prev = SCLK;
         end
         if (SCLK === 1'b1) nhigh++;
      end
      bus.rd = 1'b0;
      checks++;
      if (rise != 20) begin
         failures++;
         $display("FAIL irq_rise got=%0d want=20", rise);
      end
      checks++;
      if (rise < 1 || tmt_h[rise] !== 1'b1 || tmt_h[rise-1] !== 1'b0) begin
         failures++;
         $display("FAIL irq_vs_tmt got=rise%0d want=tmt_edge", rise);
      end
      checks++;
      if (ntog != 16 || last_t - first_t != 15 || nhigh != 8) begin
         failures++;
         $display("FAIL irq_sclk got=t%0d span%0d h%0d want=16/15/8",
                  ntog, last_t - first_t, nhigh);
      end
      rd_reg(3'd0, d);
      checks++;
      if (d !== 16'h005A) begin
         failures++;
         $display("FAIL irq_rx got=%h want=005a", d);
      end
      wr_reg(3'd3, 16'h0);
      wr_reg(3'd4, 16'h9);
   endtask

   task automatic test_reset_midword();
      logic [15:0] d;
      wr_reg(3'd3, 16'h1);
      wr_reg(3'd1, 16'h77);
      wr_reg(3'd1, 16'h78);
      repeat (60) @(negedge clk);
      checks++;
      if (SS_n !== 1'b0) begin
         failures++;
         $display("FAIL mid_active got=%b want=0", SS_n);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({SS_n, SCLK, MOSI, bus.irq} !== 4'b1000) begin
         failures++;
         $display("FAIL mid_pins got=%b want=1000",
                  {SS_n, SCLK, MOSI, bus.irq});
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd_reg(3'd2, d);
      checks++;
      if (d !== 16'h0001) begin
         failures++;
         $display("FAIL mid_status got=%h want=0001", d);
      end
      rd_reg(3'd0, d);
      checks++;
      if (d !== 16'h0000) begin
         failures++;
         $display("FAIL mid_rx got=%h want=0000", d);
      end
      rd_reg(3'd3, d);
      checks++;
      if (d !== 16'h0000 || SCLK !== 1'b0) begin
         failures++;
         $display("FAIL mid_ctrl got=%h/%b want=0000/0", d, SCLK);
      end
   endtask

   initial begin
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      test_reset();
      test_mode0();
      test_modes();
      test_back_to_back();
      test_rx_overrun();
      test_irq_fast();
      test_reset_midword();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
